// File: rtl/pll_video_reconfig_seq_pkg.sv
// Shared definitions for the video PLL retune sequencer: register map, state
// encoding and the per-standard PLL counter table.
package pll_video_cfg_pkg;

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LOCK_RUN   = 16;
  localparam int unsigned LOCK_CNT_W = $clog2(LOCK_RUN);

  localparam logic [ADDR_W-1:0] REG_MODE   = 6'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS = 6'h01;
  localparam logic [ADDR_W-1:0] REG_START  = 6'h02;
  localparam logic [ADDR_W-1:0] REG_M      = 6'h04;
  localparam logic [ADDR_W-1:0] REG_C      = 6'h05;
  localparam logic [ADDR_W-1:0] REG_K      = 6'h07;

  localparam logic [DATA_W-1:0] MODE_POLL = 32'h0000_0001;
  localparam logic [DATA_W-1:0] START_GO  = 32'h0000_0001;

  // Index 0 is NTSC (53.693175 MHz), index 1 is PAL (53.203425 MHz).
  localparam logic [DATA_W-1:0] M_CNT_NTSC  = 32'h0000_0404;
  localparam logic [DATA_W-1:0] M_CNT_PAL   = 32'h0000_0404;
  localparam logic [DATA_W-1:0] K_FRAC_NTSC = 32'd2537930535;
  localparam logic [DATA_W-1:0] K_FRAC_PAL  = 32'd2201376898;
  // C0 select lives in bits [22:18]; zero there addresses counter C0.
  localparam logic [DATA_W-1:0] C0_CNT_NTSC = 32'h0000_0404;
  localparam logic [DATA_W-1:0] C0_CNT_PAL  = 32'h0000_0404;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_M,
    ST_WR_K,
    ST_WR_C0,
    ST_WR_START,
    ST_POLL,
    ST_WAIT_LOCK,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mgmt_wr_t;

  // Address/data pair issued by each write state for the chosen standard.
  function automatic mgmt_wr_t write_for(state_e st, logic pal);
    mgmt_wr_t w;
    w = '0;
    case (st)
      ST_WR_MODE:  begin w.addr = REG_MODE;  w.data = MODE_POLL; end
      ST_WR_M:     begin w.addr = REG_M;     w.data = pal ? M_CNT_PAL  : M_CNT_NTSC;  end
      ST_WR_K:     begin w.addr = REG_K;     w.data = pal ? K_FRAC_PAL : K_FRAC_NTSC; end
      ST_WR_C0:    begin w.addr = REG_C;     w.data = pal ? C0_CNT_PAL : C0_CNT_NTSC; end
      ST_WR_START: begin w.addr = REG_START; w.data = START_GO;  end
      default:     w = '0;
    endcase
    return w;
  endfunction

  function automatic state_e next_write(state_e st);
    case (st)
      ST_WR_MODE: return ST_WR_M;
      ST_WR_M:    return ST_WR_K;
      ST_WR_K:    return ST_WR_C0;
      ST_WR_C0:   return ST_WR_START;
      default:    return ST_POLL;
    endcase
  endfunction

endpackage

// File: rtl/pll_video_reconfig_seq_if.sv
// Avalon-MM management port toward the PLL reconfiguration controller.
interface pll_video_reconfig_seq_if;
  import pll_video_cfg_pkg::*;

  logic [ADDR_W-1:0] mgmt_address;
  logic              mgmt_write;
  logic              mgmt_read;
  logic [DATA_W-1:0] mgmt_writedata;
  logic [DATA_W-1:0] mgmt_readdata;
  logic              mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/pll_video_reconfig_seq_sync.sv
// Multi-stage flop synchroniser for the asynchronous standard select and lock inputs.
module pll_video_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pll_video_reconfig_seq.sv
// Retunes the video PLL between NTSC and PAL by writing the reconfig controller,
// polling for completion and waiting for a stable lock.
module pll_video_reconfig_seq
  import pll_video_cfg_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1_000_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pal_sel_i,
  input  logic                      cfg_req_i,
  input  logic                      pll_locked_i,
  pll_video_reconfig_seq_if.master  mgmt,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      applied_pal_o
);

  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);

  logic [1:0] sync_q;
  logic       pal_sync;
  logic       locked_sync;
  logic       rd_unused;

  pll_video_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({pll_locked_i, pal_sel_i}),
    .q_o (sync_q)
  );

  assign pal_sync    = sync_q[0];
  assign locked_sync = sync_q[1];
  assign rd_unused   = ^mgmt.mgmt_readdata[DATA_W-1:1];

  state_e                state_q,    state_d;
  logic                  write_q,    write_d;
  logic                  read_q,     read_d;
  logic [ADDR_W-1:0]     addr_q,     addr_d;
  logic [DATA_W-1:0]     data_q,     data_d;
  logic                  target_q,   target_d;
  logic                  applied_q,  applied_d;
  logic                  err_q,      err_d;
  logic                  done_q,     done_d;
  logic                  busy_q,     busy_d;
  logic [TMO_W-1:0]      tmo_q,      tmo_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  mgmt_wr_t              wr;
  logic                  tmo_hit;
  logic                  xfer_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      target_q   <= 1'b0;
      applied_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      target_q   <= target_d;
      applied_q  <= applied_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Each access raises its strobe the cycle after entering a state, so strobes
  // are always separated by at least one idle cycle.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    read_d     = read_q;
    addr_d     = addr_q;
    data_d     = data_q;
    target_d   = target_q;
    applied_d  = applied_q;
    err_d      = err_q;
    done_d     = 1'b0;
    tmo_d      = tmo_q;
    lock_cnt_d = lock_cnt_q;
    wr         = write_for(state_q, target_q);
    tmo_hit    = (tmo_q == TMO_W'(LOCK_TIMEOUT));
    xfer_done  = (write_q | read_q) & ~mgmt.mgmt_waitrequest;

    case (state_q)
      ST_IDLE: begin
        if ((pal_sync != applied_q) || cfg_req_i) begin
          state_d  = ST_WR_MODE;
          target_d = pal_sync;
          err_d    = 1'b0;
        end
      end
      ST_WR_MODE, ST_WR_M, ST_WR_K, ST_WR_C0, ST_WR_START: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = wr.addr;
          data_d  = wr.data;
        end else if (xfer_done) begin
          write_d = 1'b0;
          state_d = next_write(state_q);
          if (state_q == ST_WR_START) tmo_d = '0;
        end
      end
      ST_POLL: begin
        if (tmo_hit) begin
          read_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (!read_q) begin
            read_d = 1'b1;
            addr_d = REG_STATUS;
            data_d = '0;
          end else if (xfer_done) begin
            read_d = 1'b0;
            if (mgmt.mgmt_readdata[0]) begin
              state_d    = ST_WAIT_LOCK;
              tmo_d      = '0;
              lock_cnt_d = '0;
            end
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          // A lock drop restarts the run but leaves the timeout running.
          if (!locked_sync) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_CNT_W'(LOCK_RUN - 1)) begin
            done_d    = 1'b1;
            applied_d = target_q;
            state_d   = ST_IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
          end
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_write     = write_q;
  assign mgmt.mgmt_read      = read_q;
  assign mgmt.mgmt_writedata = data_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign applied_pal_o       = applied_q;

endmodule

// File: tb/tb_pll_video_reconfig_seq.sv
// Directed bench: a scripted reconfig-controller model feeds a write scoreboard
// filled as each retune is requested.
module tb_pll_video_reconfig_seq;

  localparam logic [31:0] K_NTSC = 32'd2537930535;
  localparam logic [31:0] K_PAL  = 32'd2201376898;
  localparam logic [31:0] M_VAL  = 32'h0000_0404;
  localparam logic [31:0] C_VAL  = 32'h0000_0404;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          hold;
    int          gap;
  } exp_t;

  logic clk, rst, pal_sel, cfg_req, pll_locked;
  logic busy, done, err, applied_pal;

  int   checks = 0, failures = 0;
  int   cyc = 0, done_cnt = 0, read_cnt = 0, strobe_seen = 0;
  int   rw_overlap = 0, unstable = 0, start_cyc = 0;
  logic status_val = 1'b0;
  logic stall_arm = 1'b0;
  logic [5:0] stall_addr = 6'h00;
  int   stall_n = 0;
  exp_t sb_q[$];

  pll_video_reconfig_seq_if mgmt();

  pll_video_reconfig_seq #(.LOCK_TIMEOUT(100), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pal_sel_i     (pal_sel),
    .cfg_req_i     (cfg_req),
    .pll_locked_i  (pll_locked),
    .mgmt          (mgmt.master),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .applied_pal_o (applied_pal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic void push_seq(input bit pal, input int k_hold);
    exp_t e;
    e = '{6'h00, 32'h1, 1, -1};                    sb_q.push_back(e);
    e = '{6'h04, M_VAL, 1, 1};                     sb_q.push_back(e);
    e = '{6'h07, pal ? K_PAL : K_NTSC, k_hold, 1}; sb_q.push_back(e);
    e = '{6'h05, C_VAL, 1, 1};                     sb_q.push_back(e);
    e = '{6'h02, 32'h1, 1, 1};                     sb_q.push_back(e);
  endfunction

  task automatic wait_done(input string tag, input int max);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (done_cnt != start) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_read(input string tag, input int max);
    int start;
    bit seen;
    start = read_cnt;
    seen  = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (read_cnt != start) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Controller model: stalls on request, answers status reads, pops the scoreboard on each completed write.
  initial begin : slave
    int          hold, gap, stall_cnt, gap_rise;
    logic [5:0]  cap_a;
    logic [31:0] cap_d;
    exp_t        e;
    hold = 0; gap = 0; stall_cnt = 0; gap_rise = 0; cap_a = '0; cap_d = '0;
    mgmt.mgmt_waitrequest = 1'b0;
    mgmt.mgmt_readdata    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; gap = 0; stall_cnt = 0;
        mgmt.mgmt_waitrequest = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (mgmt.mgmt_write && mgmt.mgmt_read) rw_overlap++;
        if (mgmt.mgmt_write || mgmt.mgmt_read) begin
          if (hold == 0) begin
            cap_a = mgmt.mgmt_address; cap_d = mgmt.mgmt_writedata;
            gap_rise = gap; strobe_seen++;
            if (mgmt.mgmt_write && stall_arm && cap_a == stall_addr) begin
              stall_cnt = stall_n; stall_arm = 1'b0;
            end
          end else if (mgmt.mgmt_address != cap_a || mgmt.mgmt_writedata != cap_d) begin
            unstable++;
          end
          hold++;
          if (stall_cnt > 0) begin mgmt.mgmt_waitrequest = 1'b1; stall_cnt--; end
          else mgmt.mgmt_waitrequest = 1'b0;
          mgmt.mgmt_readdata = mgmt.mgmt_read ? {31'd0, status_val} : 32'd0;
          if (!mgmt.mgmt_waitrequest) begin
            if (mgmt.mgmt_write) begin
              chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
              if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(cap_a), 64'(e.addr));
                chk("wr_data", 64'(cap_d), 64'(e.data));
                chk("wr_hold", 64'(hold), 64'(e.hold));
                if (e.gap >= 0) chk("wr_gap", 64'(gap_rise), 64'(e.gap));
              end
              if (cap_a == 6'h02) start_cyc = cyc;
            end else begin
              read_cnt++;
              chk("rd_addr", 64'(cap_a), 64'h01);
            end
            hold = 0; gap = 0;
          end
        end else begin
          gap++;
          mgmt.mgmt_waitrequest = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int n0, t0, el;
    rst = 1'b1; pal_sel = 1'b0; cfg_req = 1'b0; pll_locked = 1'b1;
    repeat (4) step();
    chk("rst_write", 64'(mgmt.mgmt_write), 64'd0);
    chk("rst_read",  64'(mgmt.mgmt_read),  64'd0);
    chk("rst_addr",  64'(mgmt.mgmt_address), 64'd0);
    chk("rst_data",  64'(mgmt.mgmt_writedata), 64'd0);
    chk("rst_flags", 64'({busy, done, err, applied_pal}), 64'd0);
    rst = 1'b0;

    // Power-on NTSC matches request: nothing happens.
    repeat (1000) step();
    chk("idle_strobes", 64'(strobe_seen), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_applied", 64'(applied_pal), 64'd0);

    // Retune to PAL with WR_K stalled 5 cycles.
    push_seq(1'b1, 6);
    stall_addr = 6'h07; stall_n = 5; stall_arm = 1'b1;
    status_val = 1'b1;
    n0 = done_cnt;
    pal_sel = 1'b1;
    wait_done("pal_done", 300);
    chk("pal_applied", 64'(applied_pal), 64'd1);
    chk("pal_busy", 64'(busy), 64'd0);
    repeat (3) step();
    chk("pal_done_once", 64'(done_cnt - n0), 64'd1);
    chk("pal_read_seen", 64'(read_cnt != 0), 64'd1);
    chk("pal_sb_empty", 64'(sb_q.size()), 64'd0);

    // Status never completes: timeout then automatic retry.
    push_seq(1'b0, 1);
    push_seq(1'b0, 1);
    status_val = 1'b0;
    pal_sel = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        step();
        if (err) seen = 1'b1;
      end
      chk("tmo_err_seen", 64'(seen), 64'd1);
    end
    el = cyc - start_cyc;
    chk("tmo_latency", 64'(el >= 95 && el <= 110), 64'd1);
    chk("tmo_applied", 64'(applied_pal), 64'd1);
    status_val = 1'b1;
    step();
    chk("tmo_idle_busy", 64'(busy), 64'd0);
    chk("tmo_err_sticky", 64'(err), 64'd1);
    wait_done("retry_done", 300);
    chk("retry_applied", 64'(applied_pal), 64'd0);
    chk("retry_err_clr", 64'(err), 64'd0);
    chk("retry_sb_empty", 64'(sb_q.size()), 64'd0);

    // pal_sel flips back during POLL: PAL finishes, then NTSC reruns.
    push_seq(1'b1, 1);
    push_seq(1'b0, 1);
    status_val = 1'b0;
    pal_sel = 1'b1;
    wait_read("toggle_in_poll", 300);
    pal_sel = 1'b0;
    repeat (4) step();
    status_val = 1'b1;
    wait_done("toggle_first_done", 300);
    chk("toggle_first_pal", 64'(applied_pal), 64'd1);
    wait_done("toggle_second_done", 300);
    chk("toggle_second_ntsc", 64'(applied_pal), 64'd0);
    chk("toggle_sb_empty", 64'(sb_q.size()), 64'd0);

    // Forced rewrite; lock drop inside the window restarts it; cfg_req while busy ignored.
    push_seq(1'b0, 1);
    pll_locked = 1'b0;
    status_val = 1'b1;
    step();
    cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
    wait_read("cfg_poll_done", 300);
    pll_locked = 1'b1;
    repeat (8) step();
    pll_locked = 1'b0;
    cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
    repeat (2) step();
    pll_locked = 1'b1;
    t0 = cyc;
    wait_done("relock_done", 100);
    el = cyc - t0;
    chk("relock_window", 64'(el >= 17 && el <= 19), 64'd1);
    n0 = strobe_seen;
    repeat (100) step();
    chk("cfg_busy_dropped", 64'(strobe_seen - n0), 64'd0);
    chk("cfg_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset while WR_M is stalled.
    begin
      exp_t e;
      e = '{6'h00, 32'h1, 1, -1};
      sb_q.push_back(e);
    end
    stall_addr = 6'h04; stall_n = 20; stall_arm = 1'b1;
    pal_sel = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        step();
        if (mgmt.mgmt_write && mgmt.mgmt_address == 6'h04) seen = 1'b1;
      end
      chk("wrm_reached", 64'(seen), 64'd1);
    end
    rst = 1'b1;
    pal_sel = 1'b0;
    #1;
    chk("arst_write", 64'(mgmt.mgmt_write), 64'd0);
    chk("arst_addr", 64'(mgmt.mgmt_address), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (3) step();
    rst = 1'b0;
    stall_arm = 1'b0;
    n0 = strobe_seen;
    repeat (50) step();
    chk("post_rst_idle", 64'(strobe_seen - n0), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_applied", 64'(applied_pal), 64'd0);

    chk("rw_overlap", 64'(rw_overlap), 64'd0);
    chk("stable_under_wait", 64'(unstable), 64'd0);
    chk("sb_final_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
